// File: rtl/pwl_tanh_5_bwd.sv
// Backward pass of the 5-slice Q8.8 PWL tanh: g_out = g * slope(x), two-stage
// valid/ready pipeline, plus a saturating count of dead-gradient samples.
module pwl_tanh_5_bwd #(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic signed [15:0]      x_in,
  input  logic signed [15:0]      g_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic signed [15:0]      g_out,
  input  logic                    clear_stats,
  output logic        [CNT_W-1:0] sat_count
);

  typedef enum logic [1:0] {SL_ZERO, SL_86, SL_236} slope_e;

  localparam logic signed [15:0] BP_NEG_OUT = -16'sd512;
  localparam logic signed [15:0] BP_NEG_IN  = -16'sd128;
  localparam logic signed [15:0] BP_POS_IN  =  16'sd128;
  localparam logic signed [15:0] BP_POS_OUT =  16'sd512;
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  slope_e             slope_sel;
  logic signed [31:0] g_ext;
  logic signed [31:0] prod_86;
  logic signed [31:0] prod_236;
  logic signed [31:0] prod_sel;

  logic               s1_v;
  logic signed [31:0] s1_prod;
  logic               s2_free;
  logic               s1_adv;
  logic               accept;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    slope_sel = SL_ZERO;
    if (x_in >= BP_NEG_OUT && x_in < BP_NEG_IN)
      slope_sel = SL_86;
    else if (x_in >= BP_NEG_IN && x_in < BP_POS_IN)
      slope_sel = SL_236;
    else if (x_in >= BP_POS_IN && x_in < BP_POS_OUT)
      slope_sel = SL_86;
  end

  // Shift-and-add multipliers: 86 = 64+16+4+2, 236 = 256-16-4.
  assign g_ext    = {{16{g_in[15]}}, g_in};
  assign prod_86  = (g_ext <<< 6) + (g_ext <<< 4) + (g_ext <<< 2) + (g_ext <<< 1);
  assign prod_236 = (g_ext <<< 8) - (g_ext <<< 4) - (g_ext <<< 2);

  always_comb begin
    prod_sel = '0;
    case (slope_sel)
      SL_86:   prod_sel = prod_86;
      SL_236:  prod_sel = prod_236;
      default: prod_sel = '0;
    endcase
  end

  assign s2_free  = !valid_out || ready_out;
  assign s1_adv   = s1_v && s2_free;
  assign ready_in = !s1_v || s2_free;
  assign accept   = valid_in && ready_in;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_prod <= '0;
    end else if (accept) begin
      s1_v    <= 1'b1;
      s1_prod <= prod_sel;
    end else if (s1_adv) begin
      s1_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      g_out     <= '0;
    end else if (s1_adv) begin
      valid_out <= 1'b1;
      g_out     <= s1_prod[23:8];
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

  // Bits outside [23:8] are dropped by the Q8.8 rescale; floor rounding falls
  // out of discarding the low byte of a two's-complement product.
  logic unused_prod_bits;
  assign unused_prod_bits = ^{s1_prod[31:24], s1_prod[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_count <= '0;
    else if (clear_stats)
      sat_count <= '0;
    else if (accept && slope_sel == SL_ZERO && sat_count != CNT_MAX)
      sat_count <= sat_count + 1'b1;
  end

endmodule
